// File: rtl/prim_onehot_demux_pkg.sv
// Shared helpers for the one-hot stream demultiplexer: select classification and defaults.
package prim_onehot_demux_pkg;

   localparam int unsigned DefaultWidth    = 32;
   localparam int unsigned DefaultOutputs  = 8;
   localparam int unsigned DefaultCntWidth = 8;

   // Helpers take a fixed wide vector; narrower selects are zero-extended, which keeps
   // the one-hot property intact.
   localparam int unsigned MaxSelWidth = 64;

   typedef logic [MaxSelWidth-1:0] sel_vec_t;

   typedef enum logic [1:0] {
      SelZero,
      SelOneHot,
      SelMulti
   } sel_kind_e;

   function automatic logic is_onehot0(sel_vec_t v);
      return (v & (v - sel_vec_t'(1))) == '0;
   endfunction

   function automatic logic is_onehot(sel_vec_t v);
      return is_onehot0(v) && (|v);
   endfunction

   function automatic sel_kind_e sel_kind(sel_vec_t v);
      sel_kind_e kind;
      if (!(|v)) begin
         kind = SelZero;
      end else if (is_onehot(v)) begin
         kind = SelOneHot;
      end else begin
         kind = SelMulti;
      end
      return kind;
   endfunction

endpackage

// File: rtl/prim_onehot_check.sv
// Combinational classifier for a destination select: exactly one, none, or several bits set.
module prim_onehot_check
   import prim_onehot_demux_pkg::*;
#(
   parameter int unsigned Width = DefaultOutputs
) (
   input  logic [Width-1:0] sel_i,
   output logic             onehot_o,
   output logic             zero_o,
   output logic             multi_o
);

   if (Width > MaxSelWidth) begin : gen_width_check
      $error("prim_onehot_check: Width exceeds MaxSelWidth");
   end

   sel_vec_t  sel_ext;
   sel_kind_e kind;

   always_comb begin
      sel_ext  = sel_vec_t'(sel_i);
      kind     = sel_kind(sel_ext);
      onehot_o = (kind == SelOneHot);
      zero_o   = (kind == SelZero);
      multi_o  = (kind == SelMulti);
   end

endmodule

// File: rtl/prim_onehot_demux_stream.sv
// One-stage valid/ready demux: a beat is held and offered to exactly the destination named by
// its one-hot select; zero or multi-hot selects are consumed and counted as drops.
module prim_onehot_demux_stream
   import prim_onehot_demux_pkg::*;
#(
   parameter int unsigned Width    = DefaultWidth,
   parameter int unsigned Outputs  = DefaultOutputs,
   parameter int unsigned CntWidth = DefaultCntWidth
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [Width-1:0]    data_i,
   input  logic [Outputs-1:0]  sel_i,
   output logic [Outputs-1:0]  valid_o,
   input  logic [Outputs-1:0]  ready_i,
   output logic [Width-1:0]    data_o,
   input  logic                err_clr_i,
   output logic                err_o,
   output logic [CntWidth-1:0] drop_cnt_o
);

   if (Outputs < 2) begin : gen_outputs_check
      $error("prim_onehot_demux_stream: Outputs must be at least 2");
   end

   logic                full_q, full_d;
   logic [Width-1:0]    data_q, data_d;
   logic [Outputs-1:0]  sel_q, sel_d;
   logic                err_q, err_d;
   logic [CntWidth-1:0] drop_cnt_q, drop_cnt_d;

   logic sel_onehot, sel_zero, sel_multi;
   logic out_fire, accept, load, drop;

   prim_onehot_check #(
      .Width(Outputs)
   ) u_sel_check (
      .sel_i   (sel_i),
      .onehot_o(sel_onehot),
      .zero_o  (sel_zero),
      .multi_o (sel_multi)
   );

   // ready_i -> ready_o is combinational so a draining stage can reload without a bubble.
   always_comb begin
      valid_o  = full_q ? sel_q : '0;
      data_o   = data_q;
      out_fire = |(valid_o & ready_i);
      ready_o  = !full_q || out_fire;
      accept   = valid_i && ready_o;
      load     = accept && sel_onehot;
      drop     = accept && (sel_zero || sel_multi);
   end

   always_comb begin
      full_d = load || (full_q && !out_fire);
      data_d = load ? data_i : data_q;
      sel_d  = load ? sel_i  : sel_q;

      // A drop in the same cycle as a clear wins: the count restarts at one.
      drop_cnt_d = drop_cnt_q;
      err_d      = err_q;
      if (err_clr_i) begin
         drop_cnt_d = drop ? CntWidth'(1) : '0;
         err_d      = drop && sel_multi;
      end else if (drop) begin
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CntWidth'(1);
         end
         err_d = err_q || sel_multi;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q     <= 1'b0;
         data_q     <= '0;
         sel_q      <= '0;
         err_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         full_q     <= full_d;
         data_q     <= data_d;
         sel_q      <= sel_d;
         err_q      <= err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign err_o      = err_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_prim_onehot_demux_stream.sv
// Scoreboard bench for prim_onehot_demux_stream: legal beats queue their expected output,
// a negedge monitor pops and compares whenever a destination fires.
module tb_prim_onehot_demux_stream;

   localparam int unsigned Width    = 32;
   localparam int unsigned Outputs  = 8;
   localparam int unsigned CntWidth = 8;

   typedef struct packed {
      logic [Outputs-1:0] sel;
      logic [Width-1:0]   data;
   } beat_t;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                valid_i = 1'b0;
   logic                ready_o;
   logic [Width-1:0]    data_i = '0;
   logic [Outputs-1:0]  sel_i = '0;
   logic [Outputs-1:0]  valid_o;
   logic [Outputs-1:0]  ready_i = '0;
   logic [Width-1:0]    data_o;
   logic                err_clr_i = 1'b0;
   logic                err_o;
   logic [CntWidth-1:0] drop_cnt_o;

   int    checks = 0;
   int    failures = 0;
   int    fires = 0;
   beat_t exp_q[$];

   prim_onehot_demux_stream #(
      .Width   (Width),
      .Outputs (Outputs),
      .CntWidth(CntWidth)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .data_i    (data_i),
      .sel_i     (sel_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .data_o    (data_o),
      .err_clr_i (err_clr_i),
      .err_o     (err_o),
      .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every fire must match the oldest outstanding legal beat.
   always @(negedge clk_i) begin
      if (!rst_i && (|(valid_o & ready_i))) begin
         fires++;
         if (exp_q.size() == 0) begin
            check("fire_unexpected", 64'(valid_o), 64'h0);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("fire_sel", 64'(valid_o), 64'(e.sel));
            check("fire_data", 64'(data_o), 64'(e.data));
         end
      end
   end

   // Entered just after a posedge; returns just after the posedge that accepted the beat.
   task automatic send(input logic [Width-1:0] d, input logic [Outputs-1:0] s,
                       output int stalls);
      beat_t b;
      stalls  = 0;
      valid_i = 1'b1;
      data_i  = d;
      sel_i   = s;
      @(negedge clk_i);
      while (!ready_o && stalls < 50) begin
         stalls++;
         @(negedge clk_i);
      end
      if (!ready_o) begin
         check("send_timeout", 64'(ready_o), 64'h1);
      end else if ($countones(s) == 1) begin
         b.sel  = s;
         b.data = d;
         exp_q.push_back(b);
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      ready_i = '1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'h0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int st;
      int total;
      int fires0;

      // Reset state
      #3;
      check("rst_valid_o", 64'(valid_o), 64'h0);
      check("rst_ready_o", 64'(ready_o), 64'h1);
      check("rst_data_o", 64'(data_o), 64'h0);
      check("rst_err_o", 64'(err_o), 64'h0);
      check("rst_drop_cnt", 64'(drop_cnt_o), 64'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Single beat, one cycle latency, then drains
      ready_i = '1;
      send(32'hA5A5_0001, 8'b0000_0100, st);
      @(negedge clk_i);
      check("t1_valid_o", 64'(valid_o), 64'h04);
      check("t1_data_o", 64'(data_o), 64'hA5A5_0001);
      @(negedge clk_i);
      check("t1_drained", 64'(valid_o), 64'h0);
      @(posedge clk_i);
      #1;

      // Backpressure: beat 1 held while beat 2 waits upstream
      ready_i = '0;
      send(32'h1, 8'h01, st);
      valid_i = 1'b1;
      data_i  = 32'h2;
      sel_i   = 8'h02;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         check("bp_ready_o", 64'(ready_o), 64'h0);
         check("bp_data_o", 64'(data_o), 64'h1);
         check("bp_valid_o", 64'(valid_o), 64'h01);
      end
      @(posedge clk_i);
      #1;
      ready_i = 8'h01;
      @(negedge clk_i);
      check("bp_fire_ready_o", 64'(ready_o), 64'h1);
      exp_q.push_back('{sel: 8'h02, data: 32'h2});
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      @(negedge clk_i);
      check("bp_next_valid_o", 64'(valid_o), 64'h02);
      check("bp_next_data_o", 64'(data_o), 64'h2);
      drain();

      // Back-to-back streaming with rotating select
      ready_i = '1;
      total   = 0;
      fires0  = fires;
      for (int i = 0; i < 16; i++) begin
         send(32'h100 + Width'(i), Outputs'(1) << (i % 8), st);
         total += st;
      end
      check("stream_stalls", 64'(total), 64'h0);
      drain();
      check("stream_fires", 64'(fires - fires0), 64'd16);

      // Multi-hot then zero select drops
      send(32'hBAD0, 8'b0001_0010, st);
      @(negedge clk_i);
      check("multi_valid_o", 64'(valid_o), 64'h0);
      check("multi_err_o", 64'(err_o), 64'h1);
      check("multi_drop_cnt", 64'(drop_cnt_o), 64'h1);
      @(posedge clk_i);
      #1;
      send(32'hBAD1, 8'h00, st);
      @(negedge clk_i);
      check("zero_drop_cnt", 64'(drop_cnt_o), 64'h2);
      check("zero_err_o", 64'(err_o), 64'h1);
      check("zero_valid_o", 64'(valid_o), 64'h0);
      @(posedge clk_i);
      #1;

      // Clear alone
      err_clr_i = 1'b1;
      @(posedge clk_i);
      #1;
      err_clr_i = 1'b0;
      check("clr_err_o", 64'(err_o), 64'h0);
      check("clr_drop_cnt", 64'(drop_cnt_o), 64'h0);

      // Saturation, then clear racing a multi-hot drop
      for (int i = 0; i < 300; i++) begin
         send(Width'(i), 8'h00, st);
      end
      @(negedge clk_i);
      check("sat_drop_cnt", 64'(drop_cnt_o), 64'd255);
      check("sat_err_o", 64'(err_o), 64'h0);
      @(posedge clk_i);
      #1;
      err_clr_i = 1'b1;
      send(32'hC0DE, 8'b1000_0001, st);
      err_clr_i = 1'b0;
      @(negedge clk_i);
      check("clrdrop_drop_cnt", 64'(drop_cnt_o), 64'h1);
      check("clrdrop_err_o", 64'(err_o), 64'h1);
      @(posedge clk_i);
      #1;

      // Asynchronous reset while a beat is held
      ready_i = '0;
      send(32'hDEAD_BEEF, 8'h08, st);
      @(negedge clk_i);
      check("held_valid_o", 64'(valid_o), 64'h08);
      #2;
      rst_i = 1'b1;
      #1;
      exp_q.delete();
      check("arst_valid_o", 64'(valid_o), 64'h0);
      check("arst_data_o", 64'(data_o), 64'h0);
      check("arst_err_o", 64'(err_o), 64'h0);
      check("arst_drop_cnt", 64'(drop_cnt_o), 64'h0);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready_o", 64'(ready_o), 64'h1);
      check("post_rst_valid_o", 64'(valid_o), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
